// File: rtl/fetch_prefetch_queue_if.sv
// Signal bundle between the prefetch queue, the instruction memory and the IF stage.
// The master modport is the prefetch queue; the slave modport is its environment.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W = 12,
  parameter int FILL_W = 3
);
  logic              redirect;
  logic [15:0]       redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              if_valid;
  logic [15:0]       if_pc;
  logic [15:0]       if_instr;
  logic              if_ready;
  logic [FILL_W-1:0] fill_level;

  // Head handshake: an entry transfers on every posedge where if_valid && if_ready;
  // if_valid never depends on if_ready, and if_pc/if_instr hold until the transfer.
  modport master (
    input  redirect, redirect_pc, imem_data, if_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, fill_level
  );

  modport slave (
    output redirect, redirect_pc, imem_data, if_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, fill_level
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue feeding the IF stage; owns the instruction memory port.
// Optional PREFETCH_JUMP_PREDECODE_EN: stop fetching after a pushed 4'hF (jump) opcode.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          ADDR_W   = 12
) (
  input logic                    clk,
  input logic                    rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);

  logic [15:0]       fpc;
  logic              inflight;
  logic [15:0]       inflight_pc;
  logic [15:0]       q_pc    [DEPTH];
  logic [15:0]       q_instr [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FILL_W-1:0] count;
  logic [FILL_W:0]   used;
  logic              halt;
  logic              issue;
  logic              push;
  logic              pop;
  logic              head_valid;

  // Credits include the outstanding fetch, so a response always has a free slot.
  assign used       = {1'b0, count} + {{FILL_W{1'b0}}, inflight};
  assign issue      = !rst && !bus.redirect && !halt && (used < (FILL_W + 1)'(DEPTH));
  assign push       = inflight && !bus.redirect;
  assign head_valid = (count != '0);
  assign pop        = head_valid && bus.if_ready;

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fpc[ADDR_W-1:0];
  assign bus.if_valid   = head_valid;
  assign bus.if_pc      = head_valid ? q_pc[rd_ptr]    : 16'h0000;
  assign bus.if_instr   = head_valid ? q_instr[rd_ptr] : 16'h0000;
  assign bus.fill_level = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 16'h0000;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (bus.redirect) begin
      fpc      <= bus.redirect_pc & 16'hFFFE;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fpc;
        fpc         <= fpc + 16'd2;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the head is masked while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= inflight_pc;
      q_instr[wr_ptr] <= bus.imem_data;
    end
  end

`ifdef PREFETCH_JUMP_PREDECODE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt <= 1'b0;
    end else if (bus.redirect) begin
      halt <= 1'b0;
    end else if (push && (bus.imem_data[15:12] == 4'hF)) begin
      halt <= 1'b1;
    end
  end
`else
  assign halt = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized ready/redirect/reset.
module tb_fetch_prefetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;
  localparam int FILL_W = 3;

  logic clk;
  logic rst;
  logic rst2;

  fetch_prefetch_queue_if #(.ADDR_W(ADDR_W), .FILL_W(FILL_W)) mif ();
  fetch_prefetch_queue_if #(.ADDR_W(ADDR_W), .FILL_W(FILL_W)) mif2 ();

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(mif)
  );
  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFC), .ADDR_W(ADDR_W)) dut2 (
    .clk(clk), .rst(rst2), .bus(mif2)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit jump6 = 1'b0;
  bit chk_en = 1'b0;

  // reference model state: queued {pc, instr} pairs plus fetch pointer and outstanding fetch
  logic [31:0] exp_q[$];
  logic [15:0] m_fpc;
  logic [15:0] m_ipc;
  bit          m_infl;
  bit          m_halt;

  // cycle snapshot of DUT outputs for directed literal checks
  logic              s_req;
  logic [ADDR_W-1:0] s_addr;
  logic              s_valid;
  logic [15:0]       s_pc;
  logic [15:0]       s_instr;
  logic [FILL_W-1:0] s_fill;
  logic              er;

  function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
    if (jump6 && a == 12'h006) return 16'hF010;
    return {1'b0, a[3:1], a};
  endfunction

  // memory models: one-cycle read latency, garbage when not requested
  always @(posedge clk) mif.imem_data  <= mif.imem_req  ? mem_word(mif.imem_addr)  : 16'hDEAD;
  always @(posedge clk) mif2.imem_data <= mif2.imem_req ? mem_word(mif2.imem_addr) : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_req();
    return !rst && !mif.redirect && !m_halt && ((exp_q.size() + int'(m_infl)) < DEPTH);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_fpc  = 16'h0000;
    m_ipc  = 16'h0000;
    m_infl = 1'b0;
    m_halt = 1'b0;
  endfunction

  task automatic model_update();
    bit          req;
    logic [15:0] w;
    req = exp_req();
    if (exp_q.size() != 0 && mif.if_ready) void'(exp_q.pop_front());
    if (mif.redirect) begin
      exp_q.delete();
      m_infl = 1'b0;
      m_fpc  = mif.redirect_pc & 16'hFFFE;
      m_halt = 1'b0;
    end else begin
      if (m_infl) begin
        w = mem_word(m_ipc[ADDR_W-1:0]);
        check("no_overflow", (exp_q.size() < DEPTH), 1'b1);
        exp_q.push_back({m_ipc, w});
`ifdef PREFETCH_JUMP_PREDECODE_EN
        if (w[15:12] == 4'hF) m_halt = 1'b1;
`endif
      end
      m_infl = req;
      if (req) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 16'd2;
      end
    end
  endtask

  // compare process: every cycle, outputs against the model, away from the posedge
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      er = exp_req();
      check("imem_req", mif.imem_req, er);
      if (er) check("imem_addr", mif.imem_addr, m_fpc[ADDR_W-1:0]);
      check("if_valid", mif.if_valid, exp_q.size() != 0);
      check("if_pc", mif.if_pc, (exp_q.size() != 0) ? exp_q[0][31:16] : 16'h0);
      check("if_instr", mif.if_instr, (exp_q.size() != 0) ? exp_q[0][15:0] : 16'h0);
      check("fill_level", mif.fill_level, exp_q.size());
    end
    s_req   = mif.imem_req;
    s_addr  = mif.imem_addr;
    s_valid = mif.if_valid;
    s_pc    = mif.if_pc;
    s_instr = mif.if_instr;
    s_fill  = mif.fill_level;
  end

  // driver: one clock cycle of inputs, model advanced at the posedge
  task automatic step(input bit ready, input bit redir, input logic [15:0] rpc, input bit r);
    @(negedge clk);
    rst             = r;
    mif.if_ready    = ready;
    mif.redirect    = redir;
    mif.redirect_pc = rpc;
    if (r) model_reset();
    @(posedge clk);
    if (!rst) model_update();
  endtask

  initial begin
    int          nreq;
    bit          seen;
    logic [11:0] maxa;
    bit          r;
    bit          rd;
    bit          rdy;

    rst = 1'b1;
    rst2 = 1'b1;
    mif.if_ready = 1'b1;   mif.redirect = 1'b0;  mif.redirect_pc = 16'h0;
    mif2.if_ready = 1'b1;  mif2.redirect = 1'b0; mif2.redirect_pc = 16'h0;
    model_reset();
    chk_en = 1'b1;

    // RESET_PC near the top of the address space wraps to zero
    @(negedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      if (c == 0) begin
        check("t4_req", mif2.imem_req, 1'b1);
        check("t4_addr0", mif2.imem_addr, 12'hFFC);
      end
      if (c == 1) check("t4_addr1", mif2.imem_addr, 12'hFFE);
      if (c == 2) begin
        check("t4_addr2", mif2.imem_addr, 12'h000);
        check("t4_valid", mif2.if_valid, 1'b1);
        check("t4_pc0", mif2.if_pc, 16'hFFFC);
        check("t4_instr0", mif2.if_instr, 16'h6FFC);
      end
      if (c == 3) check("t4_pc1", mif2.if_pc, 16'hFFFE);
      if (c == 4) check("t4_pc2", mif2.if_pc, 16'h0000);
      @(negedge clk);
    end
    rst2 = 1'b1;

    // reset values, then sequential fetch with if_ready held high
    step(1, 0, 16'h0, 1);
    step(1, 0, 16'h0, 1);
    check("rst_req", s_req, 1'b0);
    check("rst_valid", s_valid, 1'b0);
    check("rst_pc", s_pc, 16'h0);
    check("rst_fill", s_fill, 3'd0);
    for (int c = 0; c < 6; c++) begin
      step(1, 0, 16'h0, 0);
      if (c == 0) begin
        check("t1_first_req", s_req, 1'b1);
        check("t1_first_addr", s_addr, 12'h000);
      end
      if (c == 1) begin
        check("t1_addr1", s_addr, 12'h002);
        check("t1_not_valid_early", s_valid, 1'b0);
      end
      if (c == 2) begin
        check("t1_valid_latency", s_valid, 1'b1);
        check("t1_pc0", s_pc, 16'h0000);
      end
      if (c == 3) check("t1_pc1", s_pc, 16'h0002);
      if (c == 4) check("t1_pc2", s_pc, 16'h0004);
    end

    // stalled consumer: credit limit, then in-order drain and resume at 0x008
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 16'h0, 0);
      nreq += int'(s_req);
    end
    check("t2_req_count", nreq, 4);
    check("t2_fill_full", s_fill, 3'd4);
    check("t2_req_stopped", s_req, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1, 0, 16'h0, 0);
      if (c < 4) check("t2_drain_pc", s_pc, 16'(2 * c));
      if (s_req && !seen) begin
        seen = 1'b1;
        check("t2_resume_addr", s_addr, 12'h008);
      end
    end
    check("t2_resumed", seen, 1'b1);

    // redirect with three queued entries and one fetch outstanding
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    for (int c = 0; c < 4; c++) step(0, 0, 16'h0, 0);
    step(0, 1, 16'h0041, 0);
    check("t3_fill_before", s_fill, 3'd3);
    check("t3_no_req_on_redirect", s_req, 1'b0);
    for (int c = 5; c < 8; c++) begin
      step(0, 0, 16'h0, 0);
      if (c == 5) begin
        check("t3_flushed", s_fill, 3'd0);
        check("t3_flush_valid", s_valid, 1'b0);
        check("t3_req", s_req, 1'b1);
        check("t3_addr", s_addr, 12'h040);
      end
      if (c == 7) begin
        check("t3_head_valid", s_valid, 1'b1);
        check("t3_head_pc", s_pc, 16'h0040);
      end
    end

    // jump opcode at 0x0006
    step(1, 0, 16'h0, 1);
    step(1, 0, 16'h0, 1);
    jump6 = 1'b1;
    maxa = 12'h000;
    for (int c = 0; c < 20; c++) begin
      step(1, 0, 16'h0, 0);
      if (s_req && s_addr > maxa) maxa = s_addr;
    end
`ifdef PREFETCH_JUMP_PREDECODE_EN
    check("t6_last_req", maxa, 12'h008);
`else
    check("t6_past_jump", maxa > 12'h008, 1'b1);
`endif
    step(1, 1, 16'h0100, 0);
    step(1, 0, 16'h0, 0);
    check("t6_restart_req", s_req, 1'b1);
    check("t6_restart_addr", s_addr, 12'h100);
    jump6 = 1'b0;

    // randomized consumer, redirects and a mid-run reset
    step(1, 0, 16'h0, 1);
    for (int i = 0; i < 10000; i++) begin
      r   = (i >= 5000 && i < 5002);
      rdy = ((i % 1000) < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      rd  = !r && ($urandom_range(0, 31) == 0);
      step(rdy, rd, 16'($urandom), r);
      if (r) begin
        check("rand_rst_valid", s_valid, 1'b0);
        check("rand_rst_fill", s_fill, 3'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
